// File: rtl/port_fifo_responder_if.sv
// Port bus plus peripheral-side FIFO handshakes for port_fifo_responder.
// master = CPU initiator / peripheral driver side, slave = the responder.
interface port_fifo_responder_if #(
  parameter int WORD_WIDTH = 16
) ();
  logic [WORD_WIDTH-1:0] portaddr;
  logic [WORD_WIDTH-1:0] portval;
  logic                  portget;
  logic                  portset;
  logic [WORD_WIDTH-1:0] portout;
  logic                  port_ack;
  logic [WORD_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [WORD_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;

  modport master (
    output portaddr, portval, portget, portset, tx_ready, rx_data, rx_valid,
    input  portout, port_ack, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  portaddr, portval, portget, portset, tx_ready, rx_data, rx_valid,
    output portout, port_ack, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/port_fifo_responder.sv
// I/O port target bridging a 4-word window to a TX FIFO (CPU->peripheral)
// and an RX FIFO (peripheral->CPU), with sticky overflow/underflow flags.

module port_fifo_responder_fifo #(
  parameter int W  = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);
  localparam int unsigned DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign count  = r_cnt;
  assign rdata  = r_mem[r_rd];
  // Push is refused when full even if a pop happens in the same cycle.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr] <= wdata;
  end
endmodule

module port_fifo_responder #(
  parameter int                    WORD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] BASE_ADDR  = 16'h0010,
  parameter int                    DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  port_fifo_responder_if.slave  bus
);
  localparam int CW = DEPTH_LOG2 + 1;

  logic [1:0]            w_off;
  logic                  w_hit, w_set, w_get;
  logic                  w_tx_push, w_tx_pop, w_tx_flush, w_tx_empty, w_tx_full;
  logic                  w_rx_push, w_rx_pop, w_rx_flush, w_rx_empty, w_rx_full;
  logic                  w_ovf, w_unf, w_stat_get;
  logic [CW-1:0]         w_tx_cnt, w_rx_cnt;
  logic [WORD_WIDTH-1:0] w_tx_head, w_rx_head, w_rdata;
  logic [15:0]           w_status;

  logic [WORD_WIDTH-1:0] r_portout;
  logic                  r_ack;
  logic                  r_tx_ovf;
  logic                  r_rx_unf;

  function automatic logic [3:0] sat4(input logic [CW-1:0] c);
    logic [31:0] wide;
    wide = 32'(c);
    return (wide > 32'd15) ? 4'hF : wide[3:0];
  endfunction

  assign w_off = bus.portaddr[1:0];
  assign w_hit = (bus.portaddr[WORD_WIDTH-1:2] == BASE_ADDR[WORD_WIDTH-1:2]);
  // A simultaneous get+set is a set only.
  assign w_set = w_hit & bus.portset;
  assign w_get = w_hit & bus.portget & ~bus.portset;

  assign w_tx_push  = w_set & (w_off == 2'd0);
  assign w_ovf      = w_tx_push & w_tx_full;
  assign w_tx_flush = w_set & (w_off == 2'd2) & bus.portval[0];
  assign w_rx_flush = w_set & (w_off == 2'd2) & bus.portval[1];
  assign w_tx_pop   = ~w_tx_empty & bus.tx_ready;

  assign w_rx_push  = bus.rx_valid & ~w_rx_full;
  assign w_rx_pop   = w_get & (w_off == 2'd0) & ~w_rx_empty;
  // Empty at sample time is an underflow even if a push lands this cycle.
  assign w_unf      = w_get & (w_off == 2'd0) & w_rx_empty;
  assign w_stat_get = w_get & (w_off == 2'd1);

  port_fifo_responder_fifo #(.W(WORD_WIDTH), .AW(DEPTH_LOG2)) u_tx (
    .clk(clk), .reset_n(reset_n),
    .push(w_tx_push), .pop(w_tx_pop), .flush(w_tx_flush),
    .wdata(bus.portval), .rdata(w_tx_head), .count(w_tx_cnt),
    .empty(w_tx_empty), .full(w_tx_full)
  );

  port_fifo_responder_fifo #(.W(WORD_WIDTH), .AW(DEPTH_LOG2)) u_rx (
    .clk(clk), .reset_n(reset_n),
    .push(w_rx_push), .pop(w_rx_pop), .flush(w_rx_flush),
    .wdata(bus.rx_data), .rdata(w_rx_head), .count(w_rx_cnt),
    .empty(w_rx_empty), .full(w_rx_full)
  );

  always_comb begin
    w_status       = '0;
    w_status[0]    = w_tx_empty;
    w_status[1]    = w_tx_full;
    w_status[2]    = w_rx_empty;
    w_status[3]    = w_rx_full;
    w_status[4]    = r_tx_ovf;
    w_status[5]    = r_rx_unf;
    w_status[11:8] = sat4(w_rx_cnt);
    w_status[15:12] = sat4(w_tx_cnt);
  end

  always_comb begin
    w_rdata = '0;
    case (w_off)
      2'd0:    w_rdata = w_rx_empty ? '0 : w_rx_head;
      2'd1:    w_rdata = WORD_WIDTH'(w_status);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_portout <= '0;
      r_ack     <= 1'b0;
      r_tx_ovf  <= 1'b0;
      r_rx_unf  <= 1'b0;
    end else begin
      r_ack <= w_set | w_get;
      if (w_get) r_portout <= w_rdata;
      // STATUS read clears the sticky bits; a same-cycle event re-sets them.
      r_tx_ovf <= (r_tx_ovf & ~w_stat_get) | w_ovf;
      r_rx_unf <= (r_rx_unf & ~w_stat_get) | w_unf;
    end
  end

  assign bus.portout  = r_portout;
  assign bus.port_ack = r_ack;
  assign bus.tx_data  = w_tx_head;
  assign bus.tx_valid = ~w_tx_empty;
  assign bus.rx_ready = ~w_rx_full;
endmodule

// File: tb/tb_port_fifo_responder.sv
// Directed bench for port_fifo_responder with queue scoreboards for port
// reads and the TX stream.
module tb_port_fifo_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  port_fifo_responder_if #(.WORD_WIDTH(16)) bus ();

  port_fifo_responder #(
    .WORD_WIDTH(16), .BASE_ADDR(16'h0010), .DEPTH_LOG2(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic [15:0] ack_q[$];
  logic [15:0] m_last = 16'h0;
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    int t;
    int r;
    s = '0;
    t = tx_q.size();
    r = rx_q.size();
    s[0] = (t == 0);
    s[1] = (t == 8);
    s[2] = (r == 0);
    s[3] = (r == 8);
    s[4] = m_ovf;
    s[5] = m_unf;
    s[11:8]  = (r > 15) ? 4'hF : 4'(r);
    s[15:12] = (t > 15) ? 4'hF : 4'(t);
    return s;
  endfunction

  // TX scoreboard: every word the peripheral takes must be the next one pushed.
  always @(negedge clk) begin
    if (reset_n && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      chk("tx_word_expected", 16'(tx_q.size() != 0), 16'd1);
      if (tx_q.size() != 0) chk("tx_data", bus.tx_data, tx_q.pop_front());
    end
  end

  task automatic access(input bit get, input bit set, input logic [15:0] addr,
                        input logic [15:0] val, input bit pop = 1'b0,
                        input bit rxv = 1'b0, input logic [15:0] rxd = 16'h0);
    bit hit;
    logic [15:0] exp;
    @(posedge clk); #1;
    bus.portget = get; bus.portset = set; bus.portaddr = addr; bus.portval = val;
    bus.rx_valid = rxv; bus.rx_data = rxd;
    if (pop) bus.tx_ready = 1'b1;
    hit = (addr[15:2] == 14'h0004);
    exp = m_last;
    if (hit && get && !set) begin
      case (addr[1:0])
        2'd0: if (rx_q.size() != 0) exp = rx_q.pop_front();
              else begin exp = 16'h0; m_unf = 1'b1; end
        2'd1: begin exp = m_status(); m_ovf = 1'b0; m_unf = 1'b0; end
        default: exp = 16'h0;
      endcase
      m_last = exp;
    end
    if (rxv) begin
      chk("rx_ready", {15'h0, bus.rx_ready}, {15'h0, rx_q.size() < 8});
      if (rx_q.size() < 8) rx_q.push_back(rxd);
    end
    if (hit && set) begin
      case (addr[1:0])
        2'd0: if (tx_q.size() < 8) tx_q.push_back(val); else m_ovf = 1'b1;
        2'd2: begin
          if (val[0]) tx_q.delete();
          if (val[1]) rx_q.delete();
        end
        default: ;
      endcase
    end
    if (hit && (get || set)) ack_q.push_back(exp);
    @(posedge clk); #1;
    bus.portget = 1'b0; bus.portset = 1'b0; bus.rx_valid = 1'b0;
    if (pop) bus.tx_ready = 1'b0;
    @(negedge clk);
    chk("port_ack", {15'h0, bus.port_ack}, {15'h0, hit && (get || set)});
    if (bus.port_ack === 1'b1 && ack_q.size() != 0) chk("portout", bus.portout, ack_q.pop_front());
    else chk("portout_hold", bus.portout, m_last);
    @(negedge clk);
    chk("ack_one_cycle", {15'h0, bus.port_ack}, 16'h0);
  endtask

  task automatic drain();
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    for (int k = 0; k < 100 && tx_q.size() != 0; k++) @(negedge clk);
    chk("drain_timeout", 16'(tx_q.size()), 16'h0);
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    chk("tx_valid_drained", {15'h0, bus.tx_valid}, 16'h0);
  endtask

  initial begin
    bus.portaddr = '0; bus.portval = '0; bus.portget = 1'b0; bus.portset = 1'b0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0;
    #12;
    chk("rst_portout", bus.portout, 16'h0);
    chk("rst_ack", {15'h0, bus.port_ack}, 16'h0);
    chk("rst_tx_valid", {15'h0, bus.tx_valid}, 16'h0);
    chk("rst_rx_ready", {15'h0, bus.rx_ready}, 16'h1);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: idle status
    access(1, 0, 16'h0011, 16'h0);
    chk("t1_status", bus.portout, 16'h0005);

    // 2: fill TX, overflow, drain
    for (int i = 0; i < 8; i++) access(0, 1, 16'h0010, 16'hA000 + 16'(i));
    access(0, 1, 16'h0010, 16'hBEEF);
    access(1, 0, 16'h0011, 16'h0);
    chk("t2_status_full_ovf", bus.portout, 16'h8016);
    drain();
    access(1, 0, 16'h0011, 16'h0);
    chk("t2_ovf_cleared", bus.portout, 16'h0005);

    // 3: RX reads and underflow
    access(0, 0, 16'h0000, 16'h0, 0, 1, 16'h1234);
    access(0, 0, 16'h0000, 16'h0, 0, 1, 16'h5678);
    access(1, 0, 16'h0010, 16'h0);
    chk("t3_rx0", bus.portout, 16'h1234);
    access(1, 0, 16'h0010, 16'h0);
    chk("t3_rx1", bus.portout, 16'h5678);
    access(1, 0, 16'h0010, 16'h0);
    chk("t3_underflow_data", bus.portout, 16'h0000);
    access(1, 0, 16'h0011, 16'h0);
    chk("t3_status_unf", bus.portout, 16'h0025);
    // empty get racing a peripheral push: underflow, word kept
    access(1, 0, 16'h0010, 16'h0, 0, 1, 16'h9999);
    access(1, 0, 16'h0011, 16'h0);
    chk("t3_unf_push_status", bus.portout, 16'h0121);
    access(1, 0, 16'h0010, 16'h0);
    chk("t3_kept_word", bus.portout, 16'h9999);

    // get+set together is a set; control/reserved offsets
    access(1, 1, 16'h0010, 16'h7777);
    access(1, 0, 16'h0012, 16'h0);
    access(0, 1, 16'h0013, 16'hFFFF);
    access(1, 0, 16'h0013, 16'h0);
    drain();

    // 4: concurrent push/pop, then wrap
    for (int i = 0; i < 3; i++) access(0, 1, 16'h0010, 16'hC000 + 16'(i));
    access(0, 1, 16'h0010, 16'hC003, 1);
    access(1, 0, 16'h0011, 16'h0);
    chk("t4_count_kept", bus.portout, 16'h3004);
    drain();
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) access(0, 1, 16'h0010, 16'hD000 + 16'(i));
    drain();

    // 5: flush both FIFOs
    access(0, 1, 16'h0010, 16'hE000);
    access(0, 1, 16'h0010, 16'hE001);
    for (int i = 0; i < 9; i++) access(0, 0, 16'h0000, 16'h0, 0, 1, 16'hF000 + 16'(i));
    access(1, 0, 16'h0011, 16'h0);
    chk("t5_status_pre", bus.portout, 16'h2808);
    access(0, 1, 16'h0012, 16'h0003);
    chk("t5_tx_valid", {15'h0, bus.tx_valid}, 16'h0);
    chk("t5_rx_ready", {15'h0, bus.rx_ready}, 16'h1);
    access(1, 0, 16'h0011, 16'h0);
    chk("t5_status_post", bus.portout, 16'h0005);

    // 6: out-of-window, then reset mid-access
    access(1, 0, 16'h0020, 16'h0);
    chk("t6_oow_hold", bus.portout, 16'h0005);
    access(0, 1, 16'h0010, 16'h4242);
    @(posedge clk); #1;
    bus.portaddr = 16'h0011; bus.portget = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_portout", bus.portout, 16'h0);
    chk("t6_rst_ack", {15'h0, bus.port_ack}, 16'h0);
    chk("t6_rst_tx_valid", {15'h0, bus.tx_valid}, 16'h0);
    chk("t6_rst_rx_ready", {15'h0, bus.rx_ready}, 16'h1);
    tx_q.delete(); rx_q.delete(); ack_q.delete();
    m_last = 16'h0; m_ovf = 1'b0; m_unf = 1'b0;
    @(posedge clk); #1;
    bus.portget = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_no_ack_after", {15'h0, bus.port_ack}, 16'h0);
    chk("t6_portout_after", bus.portout, 16'h0);
    access(1, 0, 16'h0011, 16'h0);
    chk("t6_status_after_rst", bus.portout, 16'h0005);

    chk("ack_q_empty", 16'(ack_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
